// File: rtl/mem_core_nic_pkg.sv
// Shared types for the core-side memory NIC: flit layout, FSM states and the
// per-flit field builder used by the transmit serializer.
package mem_core_nic_pkg;

  localparam int unsigned AddrW          = 32;
  localparam int unsigned FlitW          = 64;
  localparam int unsigned WideW          = 256;
  localparam int unsigned CoreIdW        = 4;
  localparam int unsigned FLITS_PER_WIDE = WideW / FlitW;
  localparam int unsigned FlitBytes      = FlitW / 8;
  localparam int unsigned BeatW          = $clog2(FLITS_PER_WIDE);

  localparam logic [7:0] PayloadNarrow = 8'd8;
  localparam logic [7:0] PayloadWide   = 8'd32;

  typedef struct packed {
    logic [CoreIdW-1:0] src_core;
    logic               ipriority;
    logic               last_flit;
    logic [7:0]         payload_size;
    logic               transfer_type;
    logic               is_wide;
    logic               is_read;
    logic [AddrW-1:0]   addr;
    logic [FlitW-1:0]   data;
  } generic_flit_t;

  typedef enum logic [0:0] {TxIdle, TxSend} tx_state_t;
  typedef enum logic [0:0] {RxCollect, RxHold} rx_state_t;

  // Flit k of a packet; the address add wraps at AddrW bits.
  function automatic generic_flit_t build_flit(input logic [AddrW-1:0]   base,
                                               input logic [WideW-1:0]   wdata,
                                               input logic               is_read,
                                               input logic               wide,
                                               input logic               srf,
                                               input logic [BeatW-1:0]   k,
                                               input logic [BeatW-1:0]   last_k,
                                               input logic [CoreIdW-1:0] core);
    generic_flit_t f;
    f.addr          = base + AddrW'(k) * AddrW'(FlitBytes);
    f.data          = is_read ? '0 : wdata[k*FlitW +: FlitW];
    f.is_read       = is_read;
    f.is_wide       = wide;
    f.transfer_type = srf;
    f.payload_size  = wide ? PayloadWide : PayloadNarrow;
    f.last_flit     = (k == last_k);
    f.ipriority     = wide;
    f.src_core      = core;
    return f;
  endfunction

endpackage

// File: rtl/mem_core_nic_reassembler.sv
// Receive side: collects matching response flits into one wide beat and holds
// it until the core takes it. Foreign or overrunning flits pulse route_err.
module mem_flit_reassembler
  import mem_core_nic_pkg::*;
#(
  parameter int unsigned CORE_ID = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  generic_flit_t    flit_i,
  input  logic             flit_req_i,
  output logic             flit_ack_o,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WideW-1:0] resp_data_o,
  output logic             resp_wide_o,
  output logic             route_err_o
);

  rx_state_t        state_q;
  logic [BeatW-1:0] beat_q;
  logic [WideW-1:0] data_q;
  logic             wide_q;
  logic             err_q;
  logic             final_beat;

  // The last slot closes the packet even without last_flit set.
  assign final_beat = flit_i.last_flit || (beat_q == BeatW'(FLITS_PER_WIDE - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RxCollect;
      beat_q  <= '0;
      data_q  <= '0;
      wide_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        RxCollect: begin
          if (flit_req_i) begin
            if (flit_i.src_core != CoreIdW'(CORE_ID)) begin
              err_q <= 1'b1;
            end else begin
              beat_q <= beat_q + BeatW'(1);
              if (final_beat) begin
                wide_q  <= flit_i.is_wide;
                state_q <= RxHold;
                err_q   <= !flit_i.last_flit;
                if (flit_i.is_wide) data_q[beat_q*FlitW +: FlitW] <= flit_i.data;
                else                data_q <= WideW'(flit_i.data);
              end else begin
                data_q[beat_q*FlitW +: FlitW] <= flit_i.data;
              end
            end
          end
        end
        RxHold: begin
          if (resp_ready_i) begin
            beat_q  <= '0;
            data_q  <= '0;
            wide_q  <= 1'b0;
            state_q <= RxCollect;
          end
        end
        default: state_q <= RxCollect;
      endcase
    end
  end

  assign flit_ack_o   = (state_q == RxCollect);
  assign resp_valid_o = (state_q == RxHold);
  assign resp_data_o  = data_q;
  assign resp_wide_o  = wide_q;
  assign route_err_o  = err_q;

endmodule

// File: rtl/mem_core_nic.sv
// Core-side memory NIC: serializes core requests into 64-bit wormhole flits and
// hands response flits to the reassembler.
module mem_core_nic
  import mem_core_nic_pkg::*;
#(
  parameter int unsigned CORE_ID    = 0,
  parameter int unsigned ADDR_WIDTH = AddrW,
  parameter int unsigned WIDE_WIDTH = WideW,
  parameter int unsigned FLIT_SIZE  = FlitW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srf_mode,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_is_read,
  input  logic                  req_is_wide,
  input  logic [WIDE_WIDTH-1:0] req_wdata,
  output generic_flit_t         flit_out,
  output logic                  flit_out_req,
  input  logic                  flit_out_ack,
  input  generic_flit_t         flit_in,
  input  logic                  flit_in_req,
  output logic                  flit_in_ack,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDE_WIDTH-1:0] resp_data,
  output logic                  resp_wide,
  output logic                  route_err
);

  localparam logic [CoreIdW-1:0] CoreIdBits = CoreIdW'(CORE_ID);

  tx_state_t             state_q;
  generic_flit_t         flit_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [WIDE_WIDTH-1:0] wdata_q;
  logic                  is_read_q;
  logic                  wide_q;
  logic                  srf_q;
  logic [BeatW-1:0]      k_q;
  logic [BeatW-1:0]      last_k_q;

  logic                  eff_wide;
  logic [BeatW-1:0]      last_k_new;

  assign eff_wide   = req_is_wide && srf_mode;
  // Only wide writes carry data beyond one flit; wide reads are address-only.
  assign last_k_new = (eff_wide && !req_is_read) ? BeatW'(FLITS_PER_WIDE - 1) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= TxIdle;
      flit_q    <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      is_read_q <= 1'b0;
      wide_q    <= 1'b0;
      srf_q     <= 1'b0;
      k_q       <= '0;
      last_k_q  <= '0;
    end else begin
      unique case (state_q)
        TxIdle: begin
          if (req_valid) begin
            base_q    <= req_addr;
            wdata_q   <= req_wdata;
            is_read_q <= req_is_read;
            wide_q    <= eff_wide;
            srf_q     <= srf_mode;
            k_q       <= '0;
            last_k_q  <= last_k_new;
            flit_q    <= build_flit(req_addr, req_wdata, req_is_read, eff_wide, srf_mode,
                                    '0, last_k_new, CoreIdBits);
            state_q   <= TxSend;
          end
        end
        TxSend: begin
          if (flit_out_ack) begin
            if (flit_q.last_flit) begin
              flit_q  <= '0;
              state_q <= TxIdle;
            end else begin
              k_q    <= k_q + BeatW'(1);
              flit_q <= build_flit(base_q, wdata_q, is_read_q, wide_q, srf_q,
                                   k_q + BeatW'(1), last_k_q, CoreIdBits);
            end
          end
        end
        default: state_q <= TxIdle;
      endcase
    end
  end

  assign req_ready    = (state_q == TxIdle);
  assign flit_out_req = (state_q == TxSend);
  assign flit_out     = flit_q;

  mem_flit_reassembler #(
    .CORE_ID (CORE_ID)
  ) u_reassembler (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flit_i       (flit_in),
    .flit_req_i   (flit_in_req),
    .flit_ack_o   (flit_in_ack),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_wide_o  (resp_wide),
    .route_err_o  (route_err)
  );

endmodule
